// File: rtl/seg_scan_controller_if.sv
// seg_scan_controller_if
//   Frame-load handshake between a frame producer and seg_scan_controller.
//   bcd_in    : 16-bit BCD frame, [15:12] leftmost digit ... [3:0] rightmost
//   bcd_valid : producer has a frame on bcd_in
//   bcd_ready : controller's shadow buffer is free; transfer on valid && ready
//   modport master : producer side (drives bcd_in/bcd_valid)
//   modport slave  : controller side (drives bcd_ready)
interface seg_scan_controller_if;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        bcd_ready;

  modport master (
    output bcd_in,
    output bcd_valid,
    input  bcd_ready
  );

  modport slave (
    input  bcd_in,
    input  bcd_valid,
    output bcd_ready
  );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexed scan sequencer for a 4-digit seven-segment display.
//   A prescaler produces one slot tick every REFRESH_DIV clocks; a 2-bit
//   digit counter walks the four digit slots.  Frames arrive through a
//   valid/ready handshake into a shadow buffer and are committed to the
//   active buffer only at a frame boundary, so a frame is never torn.
//
// Parameters
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bcd_if     : frame-load handshake (slave side)
//   blank_en   : 1 = suppress leading zeros
//   brightness : PWM duty in 1/16 steps (only with SEG_BRIGHTNESS_PWM_EN)
//   countout   : current digit slot, 00 = leftmost
//   anode      : active-low digit enables (registered)
//   led_bcd    : nibble of the enabled digit (registered)
//   frame_tick : 1-cycle pulse when the last slot ends
//
// Build option
//   SEG_BRIGHTNESS_PWM_EN : adds the brightness port and a free-running
//   4-bit PWM counter that gates the selected anode after blanking.
module seg_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seg_scan_controller_if.slave  bcd_if,
  input  logic                  blank_en,
`ifdef SEG_BRIGHTNESS_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [1:0]            countout,
  output logic [3:0]            anode,
  output logic [3:0]            led_bcd,
  output logic                  frame_tick
);

  localparam int unsigned        CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]   TICK_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q,   tick_cnt_d;
  logic [1:0]       countout_q,   countout_d;
  logic             frame_tick_q, frame_tick_d;
  logic [15:0]      active_q,     active_d;
  logic [15:0]      shadow_q,     shadow_d;
  logic             pending_q,    pending_d;
  logic [3:0]       anode_q,      anode_d;
  logic [3:0]       led_bcd_q,    led_bcd_d;
`ifdef SEG_BRIGHTNESS_PWM_EN
  logic [3:0]       pwm_cnt_q,    pwm_cnt_d;
`endif

  logic             slot_tick;
  logic             frame_end;
  logic             accept;
  logic [3:0]       sel_nib;
  logic             lead_zero;
  logic [3:0]       onehot_low;
  logic             digit_en;

  // Prescaler, digit counter and handshake / commit control
  always_comb begin
    slot_tick    = (tick_cnt_q == TICK_MAX);
    frame_end    = slot_tick && (countout_q == 2'd3);
    accept       = bcd_if.bcd_valid && !pending_q;

    tick_cnt_d   = slot_tick ? '0 : tick_cnt_q + CNT_W'(1);
    countout_d   = slot_tick ? countout_q + 2'd1 : countout_q;
    frame_tick_d = frame_end;

    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;

    // Commit needs pending=1 while accept needs pending=0, so the two are
    // exclusive: a frame accepted on the frame-end edge only reaches shadow
    // and waits a whole frame before it is shown.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = bcd_if.bcd_in;
      pending_d = 1'b1;
    end
  end

  // Output stage: decode the current slot, registered below (1-cycle latency)
  always_comb begin
    sel_nib    = '0;
    lead_zero  = 1'b0;
    onehot_low = '1;
    unique case (countout_q)
      2'd0: begin
        sel_nib    = active_q[15:12];
        lead_zero  = (active_q[15:12] == 4'h0);
        onehot_low = 4'b0111;
      end
      2'd1: begin
        sel_nib    = active_q[11:8];
        lead_zero  = (active_q[15:8] == 8'h00);
        onehot_low = 4'b1011;
      end
      2'd2: begin
        sel_nib    = active_q[7:4];
        lead_zero  = (active_q[15:4] == 12'h000);
        onehot_low = 4'b1101;
      end
      2'd3: begin
        // Rightmost digit is always lit so an all-zero frame shows "0".
        sel_nib    = active_q[3:0];
        lead_zero  = 1'b0;
        onehot_low = 4'b1110;
      end
      default: begin
        sel_nib    = '0;
        lead_zero  = 1'b0;
        onehot_low = '1;
      end
    endcase

    digit_en = !(blank_en && lead_zero);
`ifdef SEG_BRIGHTNESS_PWM_EN
    // Brightness gating is applied on top of blanking.
    digit_en  = digit_en && (pwm_cnt_q < brightness);
    pwm_cnt_d = pwm_cnt_q + 4'd1;
`endif

    anode_d   = digit_en ? onehot_low : '1;
    led_bcd_d = sel_nib;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q   <= '0;
      countout_q   <= '0;
      frame_tick_q <= 1'b0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      anode_q      <= '1;
      led_bcd_q    <= '0;
`ifdef SEG_BRIGHTNESS_PWM_EN
      pwm_cnt_q    <= '0;
`endif
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      countout_q   <= countout_d;
      frame_tick_q <= frame_tick_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      led_bcd_q    <= led_bcd_d;
`ifdef SEG_BRIGHTNESS_PWM_EN
      pwm_cnt_q    <= pwm_cnt_d;
`endif
    end
  end

  assign bcd_if.bcd_ready = ~pending_q;
  assign countout         = countout_q;
  assign anode            = anode_q;
  assign led_bcd          = led_bcd_q;
  assign frame_tick       = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller
//   Self-checking bench for seg_scan_controller with REFRESH_DIV=4.
//   A behavioural model predicts every output after each rising edge; the
//   prediction is queued at the edge and compared 1 ns later.  Directed
//   scenarios add constant-expectation checks on top.
module tb_seg_scan_controller;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       reset_n;
  logic       blank_en;
  logic [3:0] brightness;
  logic [1:0] countout;
  logic [3:0] anode;
  logic [3:0] led_bcd;
  logic       frame_tick;

  seg_scan_controller_if bus ();

  seg_scan_controller #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bcd_if     (bus),
    .blank_en   (blank_en),
`ifdef SEG_BRIGHTNESS_PWM_EN
    .brightness (brightness),
`endif
    .countout   (countout),
    .anode      (anode),
    .led_bcd    (led_bcd),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [1:0] cnt;
    logic [3:0] an;
    logic [3:0] led;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned m_tick;
  int unsigned m_cnt;
  int unsigned m_pwm;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pend;
  logic [3:0]  m_an;
  logic [3:0]  m_led;
  logic        m_ft;

  always @(posedge clk) begin
    exp_t        e;
    exp_t        o;
    logic [15:0] upper;
    logic        slot;
    logic        blanked;
    if (!reset_n) begin
      m_tick = 0; m_cnt = 0; m_pwm = 0;
      m_active = '0; m_shadow = '0; m_pend = 1'b0;
      m_an = 4'hF; m_led = 4'h0; m_ft = 1'b0;
    end else begin
      slot    = (m_tick == DIV - 1);
      // Nibble of this digit and everything more significant than it.
      upper   = m_active >> (4 * (3 - m_cnt));
      m_led   = upper[3:0];
      blanked = blank_en && (m_cnt != 3) && (upper == 16'h0000);
      m_an    = blanked ? 4'hF : ~(4'(4'b1000 >> m_cnt));
`ifdef SEG_BRIGHTNESS_PWM_EN
      if (!(m_pwm < 32'(brightness))) m_an = 4'hF;
      m_pwm = (m_pwm + 1) % 16;
`endif
      m_ft = slot && (m_cnt == 3);
      if (m_ft && m_pend) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end else if (bus.bcd_valid && !m_pend) begin
        m_shadow = bus.bcd_in;
        m_pend   = 1'b1;
      end
      m_tick = slot ? 0 : m_tick + 1;
      if (slot) m_cnt = (m_cnt + 1) % 4;
    end
    e.cnt = 2'(m_cnt);
    e.an  = m_an;
    e.led = m_led;
    e.ft  = m_ft;
    e.rdy = !m_pend;
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    check_eq("countout",   32'(countout),      32'(o.cnt));
    check_eq("anode",      32'(anode),         32'(o.an));
    check_eq("led_bcd",    32'(led_bcd),       32'(o.led));
    check_eq("frame_tick", 32'(frame_tick),    32'(o.ft));
    check_eq("bcd_ready",  32'(bus.bcd_ready), 32'(o.rdy));
  end

  // ---------------- stimulus helpers ----------------
  // Present a frame and return on the negedge after it was accepted;
  // bcd_valid is left high so the caller can chain another frame.
  task automatic send(input logic [15:0] d);
    int n;
    bus.bcd_in    = d;
    bus.bcd_valid = 1'b1;
    n = 0;
    while (!bus.bcd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", 32'(bus.bcd_ready), 32'd1);
    if (n > 0 && bus.bcd_ready) check_eq("ready_at_frame_end", 32'(frame_tick), 32'd1);
    @(negedge clk);
  endtask

  // Wait for the pending frame to commit; returns on the frame-end negedge.
  task automatic wait_commit();
    int n;
    n = 0;
    while (!bus.bcd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("commit_ready", 32'(bus.bcd_ready), 32'd1);
    check_eq("commit_tick",  32'(frame_tick),    32'd1);
  endtask

  task automatic load(input logic [15:0] d);
    send(d);
    bus.bcd_valid = 1'b0;
    wait_commit();
  endtask

  // Called on a frame_tick negedge: checks the following full frame.
  task automatic check_frame(input logic [15:0] an_exp, input logic [15:0] led_exp);
    int d;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        d = k / 4;
`ifndef SEG_BRIGHTNESS_PWM_EN
        check_eq("frame_anode", 32'(anode), 32'(an_exp[15-4*d -: 4]));
`endif
        check_eq("frame_led", 32'(led_bcd), 32'(led_exp[15-4*d -: 4]));
      end
    end
    check_eq("frame_period", 32'(frame_tick), 32'd1);
  endtask

  task automatic check_release();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_eq("release_cnt", 32'(countout), (i == 4) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic wait_frame_tick();
    int n;
    n = 0;
    while (!frame_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_frame_tick", 32'(frame_tick), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
`ifdef SEG_BRIGHTNESS_PWM_EN
    int lit;
`endif
    reset_n       = 1'b0;
    bus.bcd_valid = 1'b0;
    bus.bcd_in    = '0;
    blank_en      = 1'b0;
    brightness    = 4'd15;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_anode", 32'(anode),         32'hF);
    check_eq("rst_cnt",   32'(countout),      32'd0);
    check_eq("rst_ready", 32'(bus.bcd_ready), 32'd1);
    check_eq("rst_led",   32'(led_bcd),       32'd0);
    check_eq("rst_ftick", 32'(frame_tick),    32'd0);
    reset_n = 1'b1;
    check_release();

    // Basic scan of 1234
    load(16'h1234);
    check_frame(16'h7BDE, 16'h1234);

    // Back-to-back frames: second is held off until the first commits
    send(16'h5678);
    send(16'h9ABC);
    bus.bcd_valid = 1'b0;
    wait_commit();
    check_frame(16'h7BDE, 16'h9ABC);

    // Accept in the frame-end cycle: old frame stays for one more frame
    repeat (15) @(negedge clk);
    bus.bcd_in    = 16'h4321;
    bus.bcd_valid = 1'b1;
    @(negedge clk);
    check_eq("sim_ftick", 32'(frame_tick),    32'd1);
    check_eq("sim_ready", 32'(bus.bcd_ready), 32'd0);
    bus.bcd_valid = 1'b0;
    @(negedge clk);
    check_eq("sim_old_led", 32'(led_bcd), 32'h9);
    repeat (15) @(negedge clk);
    check_eq("sim_commit_ftick", 32'(frame_tick),    32'd1);
    check_eq("sim_commit_ready", 32'(bus.bcd_ready), 32'd1);
    @(negedge clk);
    check_eq("sim_new_led", 32'(led_bcd), 32'h4);

    // Leading-zero blanking
    blank_en = 1'b1;
    load(16'h0007);
    check_frame(16'hFFFE, 16'h0007);
    load(16'h0000);
    check_frame(16'hFFFE, 16'h0000);
    load(16'h0105);
    check_frame(16'hFBDE, 16'h0105);
    blank_en = 1'b0;

`ifdef SEG_BRIGHTNESS_PWM_EN
    load(16'h1234);
    brightness = 4'd4;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode != 4'hF) lit++;
    end
    check_eq("pwm_b4_lit", 32'(lit), 32'd4);
    brightness = 4'd0;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode != 4'hF) lit++;
    end
    check_eq("pwm_b0_lit", 32'(lit), 32'd0);
    brightness = 4'd15;
`endif

    // Reset mid-scan with a frame pending in shadow
    n = 0;
    while (countout != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_scan_slot", 32'(countout), 32'd2);
    bus.bcd_in    = 16'h5555;
    bus.bcd_valid = 1'b1;
    @(negedge clk);
    bus.bcd_valid = 1'b0;
    check_eq("pre_rst_pending", 32'(bus.bcd_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_anode", 32'(anode),         32'hF);
    check_eq("async_rst_cnt",   32'(countout),      32'd0);
    check_eq("async_rst_ready", 32'(bus.bcd_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_release();
    wait_frame_tick();
    check_frame(16'h7BDE, 16'h0000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
